// File: rtl/edge_detector_multi.sv
// Multi-channel synchronise / debounce / edge detect with per-channel sticky flag and saturating counter.
// Latency: zero_delay_* SYNC_STAGES+1 cycles after input change (SYNC_STAGES+FILTER_CYCLES if filtered), cycle_delayed_* one more.
// Backpressure: none; outputs are level/pulse status, consumers sample them every cycle.
// Build option: EDGE_TIMESTAMP_EN adds a free-running timestamp and per-channel last_ts capture.
module edge_detector_multi #(
   parameter int CHANNELS      = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 0,
   parameter int COUNT_W       = 8,
   parameter int TS_W          = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [CHANNELS-1:0]         signal,
   input  logic [CHANNELS-1:0]         rise_en,
   input  logic [CHANNELS-1:0]         fall_en,
   input  logic [CHANNELS-1:0]         clear,
   output logic [CHANNELS-1:0]         zero_delay_rising,
   output logic [CHANNELS-1:0]         zero_delay_falling,
   output logic [CHANNELS-1:0]         zero_delay_either,
   output logic [CHANNELS-1:0]         cycle_delayed_rising,
   output logic [CHANNELS-1:0]         cycle_delayed_falling,
   output logic [CHANNELS-1:0]         cycle_delayed_either,
   output logic [CHANNELS-1:0]         sticky,
   output logic [CHANNELS*COUNT_W-1:0] edge_count,
   output logic [CHANNELS-1:0]         count_overflow,
   output logic                        any_event
`ifdef EDGE_TIMESTAMP_EN
   ,
   output logic [CHANNELS*TS_W-1:0]    last_ts
`endif
);

   // Parameter sanity: catch nonsensical configurations at elaboration.
   if (CHANNELS < 1 || SYNC_STAGES < 1 || FILTER_CYCLES < 0 || COUNT_W < 1 || TS_W < 1) begin : g_bad_params
      $error("edge_detector_multi: illegal parameter value");
   end

   logic [CHANNELS-1:0]              sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0]              sync_out;
   logic [CHANNELS-1:0]              cond;
   logic [CHANNELS-1:0]              prev;
   logic [CHANNELS-1:0]              qual;
   logic [CHANNELS-1:0][COUNT_W-1:0] cnt_q;

   // Synchroniser chain: stage 0 takes the raw asynchronous input.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= signal;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   if (FILTER_CYCLES == 0) begin : g_no_filter
      // Filter bypassed: accepted level follows the synchroniser directly.
      always_ff @(posedge clk) begin
         if (reset) cond <= '0;
         else       cond <= sync_out;
      end
   end else begin : g_filter
      localparam int            FW   = $clog2(FILTER_CYCLES + 1);
      localparam logic [FW-1:0] LAST = FW'(FILTER_CYCLES - 1);
      logic [FW-1:0] flt_cnt [CHANNELS];

      // Debounce: a new level is accepted only after FILTER_CYCLES consecutive differing samples.
      always_ff @(posedge clk) begin
         if (reset) begin
            cond <= '0;
            for (int i = 0; i < CHANNELS; i++) flt_cnt[i] <= '0;
         end else begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (sync_out[i] == cond[i]) begin
                  flt_cnt[i] <= '0;
               end else if (flt_cnt[i] == LAST) begin
                  cond[i]    <= sync_out[i];
                  flt_cnt[i] <= '0;
               end else begin
                  flt_cnt[i] <= flt_cnt[i] + FW'(1);
               end
            end
         end
      end
   end

   // Previous accepted level, plus registered copies of the zero-delay pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev                  <= '0;
         cycle_delayed_rising  <= '0;
         cycle_delayed_falling <= '0;
         cycle_delayed_either  <= '0;
      end else begin
         prev                  <= cond;
         cycle_delayed_rising  <= zero_delay_rising;
         cycle_delayed_falling <= zero_delay_falling;
         cycle_delayed_either  <= zero_delay_either;
      end
   end

   // Edges come straight from two registers, so they are glitch-free single-cycle pulses.
   assign zero_delay_rising  =  cond & ~prev;
   assign zero_delay_falling = ~cond &  prev;
   assign zero_delay_either  =  cond ^  prev;
   assign qual = (zero_delay_rising & rise_en) | (zero_delay_falling & fall_en);

   // Sticky / counter / overflow: clear wins over hold, but an edge in the clear cycle still counts as 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky         <= '0;
         count_overflow <= '0;
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (clear[i]) begin
               sticky[i]         <= qual[i];
               cnt_q[i]          <= qual[i] ? COUNT_W'(1) : '0;
               count_overflow[i] <= 1'b0;
            end else if (qual[i]) begin
               sticky[i] <= 1'b1;
               if (cnt_q[i] == {COUNT_W{1'b1}}) count_overflow[i] <= 1'b1;
               else                             cnt_q[i] <= cnt_q[i] + COUNT_W'(1);
            end
         end
      end
   end

   assign edge_count = cnt_q;
   assign any_event  = |sticky;

`ifdef EDGE_TIMESTAMP_EN
   logic [TS_W-1:0]              ts_q;
   logic [CHANNELS-1:0][TS_W-1:0] ts_cap;

   // Free-running timestamp, wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_q + TS_W'(1);
   end

   // Capture the timestamp of the cycle in which a qualified edge is seen; clear leaves it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) ts_cap[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (qual[i]) ts_cap[i] <= ts_q;
         end
      end
   end

   assign last_ts = ts_cap;
`endif

endmodule

// File: tb/tb_edge_detector_multi.sv
// Scoreboard bench: stimulus pushes cycle-tagged expectations, a negedge monitor pops and compares.
// Three instances: defaults (dut 0), FILTER_CYCLES=3 (dut 1), COUNT_W=2 (dut 2); all use TS_W=4.
// Timestamp checks run only when EDGE_TIMESTAMP_EN is defined.
module tb_edge_detector_multi;

   localparam int S_ZDR = 0, S_ZDF = 1, S_ZDE = 2, S_CDR = 3, S_CDF = 4, S_CDE = 5;
   localparam int S_STK = 6, S_CNT = 7, S_OVF = 8, S_ANY = 9, S_TS = 10;

   typedef struct {
      int          cyc;
      int          d;
      int          s;
      int          ch;
      logic [31:0] v;
      string       nm;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [3:0]  sig [4];
   logic [3:0]  ren [4];
   logic [3:0]  fen [4];
   logic [3:0]  clr [4];
   logic [3:0]  zdr [4];
   logic [3:0]  zdf [4];
   logic [3:0]  zde [4];
   logic [3:0]  cdr [4];
   logic [3:0]  cdf [4];
   logic [3:0]  cde [4];
   logic [3:0]  stk [4];
   logic [3:0]  ovf [4];
   logic        any_ev [4];
   logic [31:0] cnt0, cnt1;
   logic [7:0]  cnt2;
`ifdef EDGE_TIMESTAMP_EN
   logic [15:0] ts_bus [4];
`endif

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   rst_cyc = 0;
   exp_t sb [$];

   edge_detector_multi #(.TS_W(4)) dut0 (
      .clk(clk), .reset(reset), .signal(sig[0]), .rise_en(ren[0]), .fall_en(fen[0]), .clear(clr[0]),
      .zero_delay_rising(zdr[0]), .zero_delay_falling(zdf[0]), .zero_delay_either(zde[0]),
      .cycle_delayed_rising(cdr[0]), .cycle_delayed_falling(cdf[0]), .cycle_delayed_either(cde[0]),
      .sticky(stk[0]), .edge_count(cnt0), .count_overflow(ovf[0]), .any_event(any_ev[0])
`ifdef EDGE_TIMESTAMP_EN
      , .last_ts(ts_bus[0])
`endif
   );

   edge_detector_multi #(.FILTER_CYCLES(3), .TS_W(4)) dut1 (
      .clk(clk), .reset(reset), .signal(sig[1]), .rise_en(ren[1]), .fall_en(fen[1]), .clear(clr[1]),
      .zero_delay_rising(zdr[1]), .zero_delay_falling(zdf[1]), .zero_delay_either(zde[1]),
      .cycle_delayed_rising(cdr[1]), .cycle_delayed_falling(cdf[1]), .cycle_delayed_either(cde[1]),
      .sticky(stk[1]), .edge_count(cnt1), .count_overflow(ovf[1]), .any_event(any_ev[1])
`ifdef EDGE_TIMESTAMP_EN
      , .last_ts(ts_bus[1])
`endif
   );

   edge_detector_multi #(.COUNT_W(2), .TS_W(4)) dut2 (
      .clk(clk), .reset(reset), .signal(sig[2]), .rise_en(ren[2]), .fall_en(fen[2]), .clear(clr[2]),
      .zero_delay_rising(zdr[2]), .zero_delay_falling(zdf[2]), .zero_delay_either(zde[2]),
      .cycle_delayed_rising(cdr[2]), .cycle_delayed_falling(cdf[2]), .cycle_delayed_either(cde[2]),
      .sticky(stk[2]), .edge_count(cnt2), .count_overflow(ovf[2]), .any_event(any_ev[2])
`ifdef EDGE_TIMESTAMP_EN
      , .last_ts(ts_bus[2])
`endif
   );

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] act(int d, int s, int ch);
      logic [31:0] r;
      r = '0;
      case (s)
         S_ZDR: r = {28'b0, zdr[d]};
         S_ZDF: r = {28'b0, zdf[d]};
         S_ZDE: r = {28'b0, zde[d]};
         S_CDR: r = {28'b0, cdr[d]};
         S_CDF: r = {28'b0, cdf[d]};
         S_CDE: r = {28'b0, cde[d]};
         S_STK: r = {28'b0, stk[d]};
         S_OVF: r = {28'b0, ovf[d]};
         S_ANY: r = {31'b0, any_ev[d]};
         S_CNT: begin
            if (d == 0)      r = {24'b0, cnt0[ch*8 +: 8]};
            else if (d == 1) r = {24'b0, cnt1[ch*8 +: 8]};
            else             r = {30'b0, cnt2[ch*2 +: 2]};
         end
`ifdef EDGE_TIMESTAMP_EN
         S_TS: r = {28'b0, ts_bus[d][ch*4 +: 4]};
`endif
         default: r = 32'hDEAD_BEEF;
      endcase
      return r;
   endfunction

   task automatic exp_at(int c, int d, int s, int ch, logic [31:0] v, string nm);
      exp_t e;
      e.cyc = c; e.d = d; e.s = s; e.ch = ch; e.v = v; e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every expectation due this cycle; anything overdue is a failure too.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            logic [31:0] a;
            a = act(sb[i].d, sb[i].s, sb[i].ch);
            checks++;
            if (a !== sb[i].v) begin
               failures++;
               $display("FAIL %s cyc=%0d dut=%0d ch=%0d got=%0h want=%0h",
                        sb[i].nm, cyc, sb[i].d, sb[i].ch, a, sb[i].v);
            end
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s overdue cyc=%0d due=%0d got=none want=%0h", sb[i].nm, cyc, sb[i].cyc, sb[i].v);
            sb.delete(i);
         end
      end
   end

   initial begin
      int c;
      int n;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sig[k] = '0; ren[k] = '0; fen[k] = '0; clr[k] = '0;
      end

      // Reset state on every instance.
      for (int rc = 1; rc <= 2; rc++) begin
         for (int d = 0; d < 3; d++) begin
            exp_at(rc, d, S_ZDR, 0, 0, "rst_zdr");
            exp_at(rc, d, S_CDR, 0, 0, "rst_cdr");
            exp_at(rc, d, S_STK, 0, 0, "rst_sticky");
            exp_at(rc, d, S_OVF, 0, 0, "rst_ovf");
            exp_at(rc, d, S_ANY, 0, 0, "rst_any");
            exp_at(rc, d, S_CNT, 0, 0, "rst_cnt");
`ifdef EDGE_TIMESTAMP_EN
            exp_at(rc, d, S_TS, 0, 0, "rst_ts");
`endif
         end
      end
      tick(2);
      reset = 1'b0;
      rst_cyc = cyc;
      tick(3);

      // Basic rising edge on dut0 ch0: zd at +3, delayed at +4, count/sticky at +4.
      ren[0] = 4'hF; fen[0] = 4'h0;
      tick(1);
      c = cyc;
      sig[0][0] = 1'b1;
      exp_at(c+2, 0, S_ZDR, 0, 4'h0, "t1_zdr_early");
      exp_at(c+3, 0, S_ZDR, 0, 4'h1, "t1_zdr");
      exp_at(c+3, 0, S_ZDE, 0, 4'h1, "t1_zde");
      exp_at(c+4, 0, S_ZDR, 0, 4'h0, "t1_zdr_width");
      exp_at(c+3, 0, S_CDR, 0, 4'h0, "t1_cdr_early");
      exp_at(c+4, 0, S_CDR, 0, 4'h1, "t1_cdr");
      exp_at(c+5, 0, S_CDR, 0, 4'h0, "t1_cdr_width");
      exp_at(c+3, 0, S_CNT, 0, 0, "t1_cnt_before");
      exp_at(c+4, 0, S_CNT, 0, 1, "t1_cnt");
      exp_at(c+4, 0, S_STK, 0, 4'h1, "t1_sticky");
      exp_at(c+4, 0, S_ANY, 0, 1, "t1_any");
      tick(8);

      // Falling edge counted once fall_en is set.
      fen[0] = 4'h1;
      tick(1);
      c = cyc;
      sig[0][0] = 1'b0;
      exp_at(c+3, 0, S_ZDF, 0, 4'h1, "t4_zdf");
      exp_at(c+4, 0, S_CDF, 0, 4'h1, "t4_cdf");
      exp_at(c+4, 0, S_CNT, 0, 2, "t4_cnt2");
      tick(8);

      // Clear coinciding with a qualified edge: edge survives as count 1.
      c = cyc;
      sig[0][0] = 1'b1;
      exp_at(c+3, 0, S_ZDR, 0, 4'h1, "t4_zdr");
      exp_at(c+4, 0, S_CNT, 0, 1, "t4_clr_edge_cnt");
      exp_at(c+4, 0, S_STK, 0, 4'h1, "t4_clr_edge_sticky");
      exp_at(c+4, 0, S_OVF, 0, 4'h0, "t4_clr_edge_ovf");
      tick(3);
      clr[0] = 4'h1;
      tick(1);
      clr[0] = 4'h0;
      tick(3);

      // Clear with no edge: everything back to zero.
      c = cyc;
      clr[0] = 4'h1;
      exp_at(c+1, 0, S_CNT, 0, 0, "t4_clr_cnt");
      exp_at(c+1, 0, S_STK, 0, 4'h0, "t4_clr_sticky");
      exp_at(c+1, 0, S_ANY, 0, 0, "t4_clr_any");
      tick(1);
      clr[0] = 4'h0;
      tick(3);

      // Filter: 2-cycle pulse discarded, 5-cycle pulse gives one rise and one fall.
      ren[1] = 4'hF; fen[1] = 4'hF;
      tick(1);
      c = cyc;
      sig[1][1] = 1'b1;
      for (int j = 1; j <= 9; j++) exp_at(c+j, 1, S_ZDE, 0, 4'h0, "flt_short_zde");
      exp_at(c+10, 1, S_CNT, 1, 0, "flt_short_cnt");
      tick(2);
      sig[1][1] = 1'b0;
      tick(10);
      c = cyc;
      sig[1][1] = 1'b1;
      exp_at(c+4,  1, S_ZDR, 0, 4'h0, "flt_zdr_early");
      exp_at(c+5,  1, S_ZDR, 0, 4'h2, "flt_zdr");
      exp_at(c+6,  1, S_ZDR, 0, 4'h0, "flt_zdr_width");
      exp_at(c+6,  1, S_CNT, 1, 1, "flt_cnt1");
      exp_at(c+9,  1, S_ZDF, 0, 4'h0, "flt_zdf_early");
      exp_at(c+10, 1, S_ZDF, 0, 4'h2, "flt_zdf");
      exp_at(c+11, 1, S_CDE, 0, 4'h2, "flt_cde");
      exp_at(c+11, 1, S_CNT, 1, 2, "flt_cnt2");
      exp_at(c+11, 1, S_STK, 0, 4'h2, "flt_sticky");
      tick(5);
      sig[1][1] = 1'b0;
      tick(10);

      // Saturation: COUNT_W=2, five rising edges, falling edges not qualified.
      ren[2] = 4'hF; fen[2] = 4'h0;
      tick(1);
      for (int k = 1; k <= 5; k++) begin
         n = (k > 3) ? 3 : k;
         c = cyc;
         sig[2][2] = 1'b1;
         exp_at(c+4, 2, S_CNT, 2, n, "sat_cnt_rise");
         exp_at(c+4, 2, S_OVF, 0, (k >= 4) ? 4'h4 : 4'h0, "sat_ovf");
         exp_at(c+8, 2, S_CNT, 2, n, "sat_cnt_after_fall");
         tick(4);
         sig[2][2] = 1'b0;
         tick(4);
      end
      tick(4);

`ifdef EDGE_TIMESTAMP_EN
      // Timestamp: edge seen at ts=14, next edge 20 cycles later wraps to 2.
      ren[0] = 4'hF; fen[0] = 4'hF;
      for (int k = 0; k < 16 && (((cyc + 3 - rst_cyc) % 16) != 14); k++) tick(1);
      c = cyc;
      sig[0][1] = 1'b1;
      exp_at(c+4,  0, S_TS, 1, 14, "ts_first");
      exp_at(c+23, 0, S_TS, 1, 14, "ts_hold");
      exp_at(c+24, 0, S_TS, 1, 2, "ts_wrap");
      tick(20);
      sig[0][1] = 1'b0;
      tick(6);
`endif

      // Simultaneous rise on all channels of dut0.
      sig[0] = 4'h0; ren[0] = 4'hF; fen[0] = 4'h0;
      tick(6);
      clr[0] = 4'hF;
      tick(1);
      clr[0] = 4'h0;
      tick(1);
      c = cyc;
      sig[0] = 4'hF;
      exp_at(c+2, 0, S_ZDR, 0, 4'h0, "all_zdr_early");
      exp_at(c+3, 0, S_ZDR, 0, 4'hF, "all_zdr");
      exp_at(c+4, 0, S_STK, 0, 4'hF, "all_sticky");
      exp_at(c+4, 0, S_ANY, 0, 1, "all_any");
      for (int k = 0; k < 4; k++) exp_at(c+4, 0, S_CNT, k, 1, "all_cnt");
      tick(6);
      sig[0] = 4'h0;
      tick(6);

      // Second rise, reset asserted during the zero-delay pulse; input held high re-detects after release.
      c = cyc;
      sig[0] = 4'hF;
      exp_at(c+3, 0, S_ZDR, 0, 4'hF, "rst_mid_zdr");
      exp_at(c+4, 0, S_ZDR, 0, 4'h0, "rst_mid_zdr_clr");
      exp_at(c+4, 0, S_CDR, 0, 4'h0, "rst_mid_cdr");
      exp_at(c+4, 0, S_STK, 0, 4'h0, "rst_mid_sticky");
      exp_at(c+4, 0, S_ANY, 0, 0, "rst_mid_any");
      for (int k = 0; k < 4; k++) exp_at(c+4, 0, S_CNT, k, 0, "rst_mid_cnt");
      exp_at(c+6, 0, S_ZDR, 0, 4'h0, "post_rst_zdr_early");
      exp_at(c+7, 0, S_ZDR, 0, 4'hF, "post_rst_zdr");
      exp_at(c+8, 0, S_CNT, 0, 1, "post_rst_cnt");
      tick(3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(10);

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL leftover got=%0d pending want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Parametrised multi-channel successor to the single-channel edge detector.
- Per channel: synchroniser, optional debounce filter, rising/falling/either detection in zero-delay and one-cycle-delayed forms.
- Also per channel: qualified-edge sticky flag and saturating edge counter with overflow.
- Sits between asynchronous external inputs (buttons, sensor strobes) and the register/interrupt logic.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=1).
- FILTER_CYCLES, 0, consecutive stable cycles required before a level change is accepted; 0 = filter bypassed.
- COUNT_W, 8, width of each per-channel edge counter (>=1).
- TS_W, 16, timestamp width; used only when EDGE_TIMESTAMP_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- signal  in  CHANNELS  asynchronous raw inputs
- rise_en  in  CHANNELS  per-channel: rising edges count as qualified events
- fall_en  in  CHANNELS  per-channel: falling edges count as qualified events
- clear  in  CHANNELS  per-channel one-cycle clear of sticky, count, overflow
- zero_delay_rising  out  CHANNELS  cond & ~prev
- zero_delay_falling  out  CHANNELS  ~cond & prev
- zero_delay_either  out  CHANNELS  cond ^ prev
- cycle_delayed_rising  out  CHANNELS  zero_delay_rising registered one cycle
- cycle_delayed_falling  out  CHANNELS  registered falling
- cycle_delayed_either  out  CHANNELS  registered either
- sticky  out  CHANNELS  set on qualified edge, held until clear
- edge_count  out  CHANNELS*COUNT_W  channel i at bits [i*COUNT_W +: COUNT_W]
- count_overflow  out  CHANNELS  sticky; set when a qualified edge arrives at count = all-ones
- any_event  out  1  OR of all sticky bits

Behaviour:
- Reset (clk edge with reset=1): all synchroniser flops, cond, prev, filter counters, delayed outputs, sticky, edge_count and count_overflow go to 0.
  - All outputs therefore read 0 the cycle after reset.
  - Reset overrides clear and all edges.
- Synchroniser: per-channel chain of SYNC_STAGES flops; sync_out = last stage.
- Filter, FILTER_CYCLES=0: cond <= sync_out every cycle.
- Filter, FILTER_CYCLES=N>0: per-channel counter, width clog2(N+1).
  - If sync_out == cond: counter <= 0.
  - Otherwise counter increments; when it would reach N, cond <= sync_out and counter <= 0.
  - A pulse shorter than N cycles at sync_out is discarded entirely.
- prev <= cond every cycle. Zero-delay outputs are combinational from the cond/prev registers, so they are glitch-free and one cycle wide.
- Latency from a signal change (meeting setup) to zero_delay_* high: SYNC_STAGES + 1 cycles if FILTER_CYCLES=0, else SYNC_STAGES + N cycles. cycle_delayed_* follow one cycle later.
- Input held high through reset release is treated as a 0->1 transition. A rising edge is reported after the normal latency; this is intended.
- Qualified edge q[i] = (zero_delay_rising[i] & rise_en[i]) | (zero_delay_falling[i] & fall_en[i]). Enables are sampled in the same cycle as the edge; changing an enable never creates or cancels a reported zero_delay pulse.
- Per-channel update priority on each clk edge (reset excluded):
  - clear=1, q=0: sticky<=0, count<=0, overflow<=0.
  - clear=1, q=1: sticky<=1, count<=1, overflow<=0. The edge is never lost.
  - clear=0, q=1, count < max: count<=count+1, sticky<=1.
  - clear=0, q=1, count = max: count holds at max (saturates, no wrap), overflow<=1, sticky<=1.
  - clear=0, q=0: hold.
- Channels are fully independent; simultaneous edges on any number of channels are all recorded.
- any_event is combinational OR of sticky.

Optional Feature:
- Macro: EDGE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running TS_W-bit counter, cleared by reset, incrementing every cycle and wrapping modulo 2^TS_W.
  - Adds output last_ts (CHANNELS*TS_W, channel i at [i*TS_W +: TS_W]), reset 0.
  - On each qualified edge, last_ts[i] captures the counter value of that cycle; clear does not alter last_ts.
- Undefined: no timestamp counter, no last_ts port, no related logic.

Test Plan:
- Defaults, reset 2 cycles, signal[0] 0->1 -> zero_delay_rising[0] high exactly 1 cycle, 3 cycles after change; cycle_delayed_rising[0] at cycle 4; edge_count[0]=1, sticky[0]=1, any_event=1.
- FILTER_CYCLES=3, 2-cycle pulse on signal[1] -> no outputs, count 0; 5-cycle pulse -> one rising and one falling, rise_en=fall_en=1 gives count=2.
- COUNT_W=2, rise_en=1, fall_en=0, 5 rising edges on signal[2] -> count saturates at 3, count_overflow[2]=1; falling edges leave count unchanged.
- clear[0] asserted in same cycle as qualified edge -> next cycle count=1, sticky=1, overflow=0; clear without edge -> all 0, any_event=0 if no other sticky.
- Simultaneous rising on all 4 channels -> all four zero_delay_rising high same cycle, each count=1; reset asserted mid-pulse -> all outputs 0 next cycle.
- EDGE_TIMESTAMP_EN, TS_W=4, edge at timestamp 14 then 20 cycles later -> last_ts=14 then 2 (wrapped).
